// File: rtl/exception_unit.sv
// Precise-exception collector: tracks ID/EX causes alongside each instruction and
// commits the oldest one at MEM as a one-cycle pulse to coprocessor 0, then flushes.
module exception_unit #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DROP_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              id_valid,
    input  logic [31:0]       id_pc,
    input  logic [31:0]       id_instr,
    input  logic              id_ri,
    input  logic              id_syscall,
    input  logic              ex_ovf,
    input  logic              eret,
    output logic [66:0]       exception_bus,
    output logic              flush_id,
    output logic              flush_ex,
    output logic              flush_mem,
    output logic              in_handler,
    output logic [DROP_W-1:0] drop_count
);

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    typedef struct packed {
        logic        valid;
        logic        ri;
        logic        syscall;
        logic [31:0] pc;
        logic [31:0] instr;
    } ex_stage_t;

    typedef struct packed {
        logic        valid;
        logic        ri;
        logic        syscall;
        logic        ovf;
        logic [31:0] pc;
        logic [31:0] instr;
    } mem_stage_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        HANDLER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    ex_stage_t         ex_q, ex_d;
    mem_stage_t        mem_q, mem_d;
    logic [66:0]       bus_q, bus_d;
    logic              flush_q, flush_d;
    logic              in_handler_q, in_handler_d;
    logic [DROP_W-1:0] drop_q, drop_d;
    logic              cause_c;
    logic [66:0]       encoded_c;

    // MEM instruction is ready to raise an exception this edge
    assign cause_c = mem_q.valid & (mem_q.ri | mem_q.syscall | mem_q.ovf) & ~stall;

    // One-hot cause with RI > SYSCALL > OVF priority
    always_comb begin
        encoded_c = '0;
        if (mem_q.ri) begin
            encoded_c = {3'b010, mem_q.pc, mem_q.instr};
        end else if (mem_q.syscall) begin
            encoded_c = {3'b001, mem_q.pc, mem_q.instr};
        end else if (mem_q.ovf) begin
            encoded_c = {3'b100, mem_q.pc, mem_q.instr};
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        ex_d         = ex_q;
        mem_d        = mem_q;
        bus_d        = '0;
        flush_d      = flush_q;
        in_handler_d = in_handler_q;
        drop_d       = drop_q;

        // Tracking pipeline; a dropped HANDLER cause simply advances out of MEM
        if (flush_q) begin
            ex_d  = '0;
            mem_d = '0;
        end else if (!stall) begin
            mem_d = '{valid:   ex_q.valid,
                      ri:      ex_q.ri,
                      syscall: ex_q.syscall,
                      ovf:     ex_ovf & ex_q.valid,
                      pc:      ex_q.pc,
                      instr:   ex_q.instr};
            if (id_valid) begin
                ex_d = '{valid: 1'b1, ri: id_ri, syscall: id_syscall,
                         pc: id_pc, instr: id_instr};
            end else begin
                ex_d = '0;
            end
        end

        case (state_q)
            IDLE: begin
                if (cause_c) begin
                    bus_d        = encoded_c;
                    state_d      = FLUSH;
                    cnt_d        = '0;
                    flush_d      = 1'b1;
                    in_handler_d = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = HANDLER;
                    flush_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HANDLER: begin
                if (cause_c && (drop_q != '1)) begin
                    drop_d = drop_q + DROP_W'(1);
                end
                if (eret) begin
                    state_d      = IDLE;
                    in_handler_d = 1'b0;
                end
            end
            default: begin
                state_d      = IDLE;
                flush_d      = 1'b0;
                in_handler_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            ex_q         <= '0;
            mem_q        <= '0;
            bus_q        <= '0;
            flush_q      <= 1'b0;
            in_handler_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ex_q         <= ex_d;
            mem_q        <= mem_d;
            bus_q        <= bus_d;
            flush_q      <= flush_d;
            in_handler_q <= in_handler_d;
            drop_q       <= drop_d;
        end
    end

    assign exception_bus = bus_q;
    assign flush_id      = flush_q;
    assign flush_ex      = flush_q;
    assign flush_mem     = flush_q;
    assign in_handler    = in_handler_q;
    assign drop_count    = drop_q;

endmodule

// File: tb/tb_exception_unit.sv
// Scoreboard bench for exception_unit: directed scenarios plus random traffic,
// expected outputs come from a behavioural model of pipeline, handler and flush window.
module tb_exception_unit;

    localparam int unsigned FC   = 4;
    localparam int unsigned DW   = 3;
    localparam int          DMAX = (1 << DW) - 1;

    logic          clk = 1'b0;
    logic          reset, stall, id_valid, id_ri, id_syscall, ex_ovf, eret;
    logic [31:0]   id_pc, id_instr;
    logic [66:0]   exception_bus;
    logic          flush_id, flush_ex, flush_mem, in_handler;
    logic [DW-1:0] drop_count;

    exception_unit #(.FLUSH_CYCLES(FC), .DROP_W(DW)) dut (
        .clk(clk), .reset(reset), .stall(stall), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_ri(id_ri), .id_syscall(id_syscall),
        .ex_ovf(ex_ovf), .eret(eret), .exception_bus(exception_bus),
        .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
        .in_handler(in_handler), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          reset, stall, valid, ri, sys, ovf, eret;
        logic [31:0] pc, instr;
    } stim_t;

    typedef struct {
        bit          v, ri, sys, ovf;
        logic [31:0] pc, instr;
    } ins_t;

    typedef struct {
        logic [66:0] bus;
        bit          flush, inh;
        int          drops;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    // Behavioural model: instructions in flight, handler mode and remaining flush cycles
    ins_t        m_ex, m_mem;
    int          mode = 0;      // 0 normal, 1 flushing, 2 in handler
    int          flush_left = 0;
    int          drops = 0;
    logic [66:0] m_bus = '0;

    function automatic stim_t nop();
        stim_t s;
        s = '{default: 0};
        return s;
    endfunction

    function automatic stim_t issue(logic [31:0] pc, logic [31:0] instr, bit ri, bit sys);
        stim_t s;
        s = nop();
        s.valid = 1; s.pc = pc; s.instr = instr; s.ri = ri; s.sys = sys;
        return s;
    endfunction

    task automatic step(input stim_t s);
        exp_t e;
        bit   was_flushing, event_c;
        if (s.reset) begin
            m_ex = '{default: 0}; m_mem = '{default: 0};
            mode = 0; flush_left = 0; drops = 0; m_bus = '0;
        end else begin
            was_flushing = (flush_left > 0);
            event_c = m_mem.v && (m_mem.ri || m_mem.sys || m_mem.ovf) && !s.stall;
            m_bus = '0;
            if (mode == 0) begin
                if (event_c) begin
                    if (m_mem.ri)       m_bus = {3'b010, m_mem.pc, m_mem.instr};
                    else if (m_mem.sys) m_bus = {3'b001, m_mem.pc, m_mem.instr};
                    else                m_bus = {3'b100, m_mem.pc, m_mem.instr};
                    mode = 1;
                    flush_left = FC;
                end
            end else if (mode == 1) begin
                flush_left = flush_left - 1;
                if (flush_left == 0) mode = 2;
            end else begin
                if (event_c && drops < DMAX) drops = drops + 1;
                if (s.eret) mode = 0;
            end
            if (was_flushing) begin
                m_ex = '{default: 0}; m_mem = '{default: 0};
            end else if (!s.stall) begin
                m_mem = m_ex;
                m_mem.ovf = s.ovf && m_ex.v;
                if (s.valid) m_ex = '{v: 1, ri: s.ri, sys: s.sys, ovf: 0, pc: s.pc, instr: s.instr};
                else         m_ex = '{default: 0};
            end
        end
        e.bus = m_bus; e.flush = (flush_left > 0); e.inh = (mode != 0); e.drops = drops;
        sb.push_back(e);
    endtask

    // Apply inputs for one cycle, predict the edge outcome, advance past the edge
    task automatic drive(input stim_t s);
        reset = s.reset; stall = s.stall; id_valid = s.valid; id_pc = s.pc;
        id_instr = s.instr; id_ri = s.ri; id_syscall = s.sys; ex_ovf = s.ovf; eret = s.eret;
        step(s);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(nop());
    endtask

    task automatic do_eret();
        stim_t s;
        s = nop(); s.eret = 1;
        drive(s);
    endtask

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: each settled cycle, compare DUT outputs with the oldest prediction
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("exception_bus", exception_bus, e.bus);
                check("flush_id", 67'(flush_id), 67'(e.flush));
                check("flush_ex", 67'(flush_ex), 67'(e.flush));
                check("flush_mem", 67'(flush_mem), 67'(e.flush));
                check("in_handler", 67'(in_handler), 67'(e.inh));
                check("drop_count", 67'(drop_count), 67'(e.drops));
            end
        end
    end

    initial begin
        stim_t s;
        // Reset, then eret in IDLE must change nothing
        s = nop(); s.reset = 1;
        drive(s); drive(s);
        idle(1); do_eret(); idle(2);

        // Reserved instruction
        drive(issue(32'h00400010, 32'hFC000000, 1, 0));
        idle(8); do_eret(); idle(2);

        // Overflow on a plain add
        drive(issue(32'h00400020, 32'h00851020, 0, 0));
        s = nop(); s.ovf = 1; drive(s);
        idle(8); do_eret(); idle(2);

        // RI together with overflow reports RI only
        drive(issue(32'h00400030, 32'hFC000001, 1, 0));
        s = nop(); s.ovf = 1; drive(s);
        idle(8); do_eret(); idle(2);

        // Syscall followed by an overflowing younger instruction
        drive(issue(32'h00000100, 32'h0000000C, 0, 1));
        drive(issue(32'h00000104, 32'h00851020, 0, 0));
        s = nop(); s.ovf = 1; drive(s);
        idle(8);
        drive(issue(32'h00000200, 32'hFC000002, 1, 0));
        idle(4); do_eret(); idle(1);
        drive(issue(32'h00000300, 32'hFC000003, 1, 0));
        idle(8); do_eret(); idle(2);

        // Stall holds a pending syscall in MEM
        drive(issue(32'h00400040, 32'h0000000C, 0, 1));
        idle(1);
        s = nop(); s.stall = 1;
        drive(s); drive(s); drive(s);
        idle(8); do_eret(); idle(2);

        // Reset during the second flush cycle
        drive(issue(32'h00400050, 32'hFC000004, 1, 0));
        idle(3);
        s = nop(); s.reset = 1; drive(s);
        idle(2);
        drive(issue(32'h00400060, 32'hFC000005, 1, 0));
        idle(8); do_eret(); idle(2);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            s.reset = ($urandom_range(0, 399) == 0);
            s.stall = ($urandom_range(0, 5) == 0);
            s.valid = ($urandom_range(0, 3) != 0);
            s.ri    = ($urandom_range(0, 9) == 0);
            s.sys   = ($urandom_range(0, 9) == 0);
            s.ovf   = ($urandom_range(0, 7) == 0);
            s.eret  = ($urandom_range(0, 15) == 0);
            s.pc    = $urandom;
            s.instr = $urandom;
            drive(s);
        end
        idle(2);

        repeat (3) @(negedge clk);
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/exception_unit.md
Name: exception_unit

Overview:
- Precise-exception collector upstream of coprocessor 0.
- Tracks exception causes raised in ID (reserved instruction, syscall) and EX (arithmetic overflow) alongside the owning instruction through ID→EX→MEM.
- Commits at most one exception, in program order, at the MEM boundary.
- On commit, drives the 67-bit exception_bus to coprocessor 0 for exactly one cycle and generates pipeline flush signals.
- Suppresses further exceptions until the handler returns (eret).

Parameters:
- FLUSH_CYCLES, 2, number of cycles flush_id/flush_ex/flush_mem stay high after a commit (≥1).
- DROP_W, 8, width of the saturating suppressed-exception counter.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- stall  in  1  pipeline stall; tracking registers and commit hold while high.
- id_valid  in  1  ID holds a real instruction.
- id_pc  in  32  PC of the ID instruction.
- id_instr  in  32  instruction word in ID.
- id_ri  in  1  reserved-instruction decode in ID.
- id_syscall  in  1  syscall decode in ID.
- ex_ovf  in  1  overflow for the instruction currently in EX.
- eret  in  1  one-cycle pulse; handler return.
- exception_bus  out  67  [66]=OVF, [65]=RI, [64]=SYSCALL, [63:32]=EPC (faulting PC), [31:0]=faulting instruction word.
- flush_id, flush_ex, flush_mem  out  1 each  squash the younger instructions.
- in_handler  out  1  exception committed, eret not yet seen.
- drop_count  out  DROP_W  exceptions suppressed while in_handler; saturates at all-ones.

Behaviour:
- Reset:
  - exception_bus=0, all flush=0, in_handler=0, drop_count=0.
  - Tracking registers invalid; FSM=IDLE.
  - Reset mid-operation aborts FLUSH/HANDLER; outputs are 0 in the cycle after the reset edge.
- Tracking registers:
  - EX register: {valid, ri, syscall, pc, instr}. On a non-stalled edge it loads from ID when id_valid and no flush; otherwise it loads invalid.
  - MEM register: loads EX contents, with ovf = ex_ovf & EX.valid.
  - stall=1 holds both registers.
  - Flush invalidates both registers on every edge where a flush output is high.
- Cause priority within one instruction: RI > SYSCALL > OVF. Exactly one of bits [66:64] is ever set.
- Commit:
  - Condition: in IDLE, MEM.valid, MEM has any cause, and stall=0. The bus is registered on that edge.
  - Latency: an instruction in ID at cycle t reaches MEM at t+2; the bus is visible during t+3 only.
  - exception_bus returns to 0 the following cycle. It is all-zero whenever no commit occurred on the previous edge.
  - Program order is guaranteed because only MEM commits. A younger cause in EX/ID is flushed, never reported.
- FSM:
  - IDLE → FLUSH on commit. flush_* go high in the same cycle as the bus pulse.
  - FLUSH: a counter runs FLUSH_CYCLES cycles with flush_* high and all causes ignored. It then goes to HANDLER, and in_handler rises with the FLUSH entry.
  - HANDLER: any cause reaching MEM commit conditions is not reported. drop_count increments (saturating), and that instruction is invalidated without a flush. An eret pulse → IDLE, in_handler=0 next cycle.
  - eret in IDLE or FLUSH is ignored.
  - stall does not extend the FLUSH count.
- Simultaneous events:
  - eret and a committing cause on the same edge in HANDLER: the cause is dropped and counted, then the FSM goes to IDLE.
  - Commit and stall on the same edge: no commit; it is retried when stall falls.

Test Plan:
- Reset: assert reset 2 cycles → exception_bus=0, flush_*=0, in_handler=0, drop_count=0; eret pulse in IDLE leaves all outputs unchanged.
- RI: id_valid, id_ri, id_pc=0x00400010, id_instr=0xFC000000 at cycle t → at t+3 exception_bus={1'b0,1'b1,1'b0,32'h00400010,32'hFC000000}; flush_* high t+3..t+4; bus=0 at t+4; in_handler=1 from t+3.
- Overflow: add at pc 0x00400020 with ex_ovf during its EX cycle → single pulse with bit66=1, EPC=0x00400020; an RI+OVF instruction reports only bit65.
- Ordering/suppression: syscall at 0x100 followed by an overflowing instruction → only syscall reported, younger flushed. A later RI while in_handler → no bus pulse, drop_count=1. eret → in_handler=0; the next RI is reported normally.
- Stall: hold stall=1 for 3 cycles while a syscall instruction sits in MEM → bus stays 0; exactly one pulse the cycle after stall falls.
- Reset mid-FLUSH (FLUSH_CYCLES=4), asserted in the 2nd flush cycle → flush_* and in_handler 0 next cycle; drop_count=0; a subsequent RI commits normally.
